// File: rtl/decode_issue_ctrl_if.sv
// Fetch / writeback / redirect / issue signals between the front end and decode_issue_ctrl.
// Signal names follow the controller's port list so both sides read the same.
interface decode_issue_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            iInstValid;
    logic [XLEN-1:0] iInst;
    logic            oInstReady;
    logic            iCredRet;
    logic            iWbValid;
    logic [4:0]      iWbAddr;
    logic            iBranchTaken;
    logic            oIssueValid;
    logic            oFlush;
    logic [15:0]     oStallCnt;

    modport master (
        output iInstValid, iInst, iCredRet, iWbValid, iWbAddr, iBranchTaken,
        input  oInstReady, oIssueValid, oFlush, oStallCnt
    );

    modport slave (
        input  iInstValid, iInst, iCredRet, iWbValid, iWbAddr, iBranchTaken,
        output oInstReady, oIssueValid, oFlush, oStallCnt
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Issue sequencer ahead of the decoder: load-use scoreboard, decode-pipe tracking,
// execute skid-buffer credits and branch squash.
module decode_issue_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEC_LAT    = 2,
    parameter int unsigned SKID_DEPTH = 4,
    parameter int unsigned FLUSH_CYC  = 2
) (
    input  logic                 iClk,
    input  logic                 iRst,
    decode_issue_ctrl_if.slave   bus
);
    localparam int unsigned CW   = $clog2(SKID_DEPTH + 1);
    localparam int unsigned FW   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int unsigned Last = DEC_LAT - 1;
    localparam logic [CW-1:0] CredMax = CW'(SKID_DEPTH);
    localparam logic [CW-1:0] CredOne = CW'(1);
    localparam logic [FW-1:0] FlushInit = FW'(FLUSH_CYC - 1);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [1:0] {StRun, StDrain, StFlush} state_e;

    state_e            state_q, state_d;
    logic [DEC_LAT-1:0] pv_q, pv_d;
    logic [DEC_LAT-1:0] pl_q, pl_d;
    logic [4:0]        prd_q [DEC_LAT];
    logic [4:0]        prd_d [DEC_LAT];
    logic [31:0]       sb_q, sb_d;
    logic [CW-1:0]     cred_q, cred_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              flush_q, flush_d;
    logic [15:0]       stall_q, stall_d;

    logic [6:0]  opc;
    logic [4:0]  rs1, rs2, rd;
    logic        use_rs1, use_rs2, is_load, is_serial;
    logic        hazard, busy, mode_ok, inst_ready, accept, br;
    logic [31:0] cred_sum;

    assign opc       = bus.iInst[6:0];
    assign rd        = bus.iInst[11:7];
    assign rs1       = bus.iInst[19:15];
    assign rs2       = bus.iInst[24:20];
    assign use_rs1   = opc inside {OpR, OpI, OpLoad, OpStore, OpBranch, OpJalr};
    assign use_rs2   = opc inside {OpR, OpStore, OpBranch};
    assign is_load   = (opc == OpLoad);
    assign is_serial = (opc == OpFence) || (opc == OpSystem);
    assign br        = bus.iBranchTaken;
    assign busy      = (|pv_q) || (|sb_q);

    // A source is blocked by a pending load either retired to the scoreboard or still in the pipe.
    always_comb begin
        hazard = 1'b0;
        if (use_rs1 && rs1 != 5'd0 && sb_q[rs1]) hazard = 1'b1;
        if (use_rs2 && rs2 != 5'd0 && sb_q[rs2]) hazard = 1'b1;
        for (int unsigned i = 0; i < DEC_LAT; i++) begin
            if (pv_q[i] && pl_q[i]) begin
                if (use_rs1 && rs1 != 5'd0 && prd_q[i] == rs1) hazard = 1'b1;
                if (use_rs2 && rs2 != 5'd0 && prd_q[i] == rs2) hazard = 1'b1;
            end
        end
    end

    always_comb begin
        unique case (state_q)
            StRun:   mode_ok = !(is_serial && busy);
            StDrain: mode_ok = !busy;
            default: mode_ok = 1'b0;
        endcase
    end

    assign inst_ready = mode_ok && !hazard && (cred_q != '0) && !br;
    assign accept     = bus.iInstValid && inst_ready;

    assign bus.oInstReady  = inst_ready;
    assign bus.oIssueValid = pv_q[Last];
    assign bus.oFlush      = flush_q;
    assign bus.oStallCnt   = stall_q;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        flush_d  = 1'b0;
        sb_d     = sb_q;
        cred_d   = cred_q;
        stall_d  = stall_q;
        cred_sum = 32'(cred_q) + 32'(bus.iCredRet) + 32'($countones(pv_q));

        pv_d[0]  = accept;
        pl_d[0]  = is_load;
        prd_d[0] = rd;
        for (int unsigned i = 1; i < DEC_LAT; i++) begin
            pv_d[i]  = pv_q[i-1];
            pl_d[i]  = pl_q[i-1];
            prd_d[i] = prd_q[i-1];
        end

        if (bus.iInstValid && !inst_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;

        // Writeback clears first so a same-cycle issuing load on that register wins.
        if (bus.iWbValid) sb_d[bus.iWbAddr] = 1'b0;
        if (!br && pv_q[Last] && pl_q[Last] && prd_q[Last] != 5'd0) sb_d[prd_q[Last]] = 1'b1;
        sb_d[0] = 1'b0;

        if (br) begin
            pv_d    = '0;
            cred_d  = (cred_sum > SKID_DEPTH) ? CredMax : CW'(cred_sum);
            state_d = StFlush;
            fcnt_d  = FlushInit;
            flush_d = (state_q != StFlush);
        end else begin
            if (accept && !bus.iCredRet) begin
                cred_d = cred_q - CredOne;
            end else if (!accept && bus.iCredRet && cred_q < CredMax) begin
                cred_d = cred_q + CredOne;
            end
            unique case (state_q)
                StRun:   if (bus.iInstValid && is_serial && busy) state_d = StDrain;
                StDrain: if (!busy) state_d = StRun;
                StFlush: begin
                    if (fcnt_q == '0) state_d = StRun;
                    else fcnt_d = fcnt_q - FW'(1);
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q <= StRun;
            pv_q    <= '0;
            pl_q    <= '0;
            for (int unsigned i = 0; i < DEC_LAT; i++) prd_q[i] <= 5'd0;
            sb_q    <= '0;
            cred_q  <= CredMax;
            fcnt_q  <= '0;
            flush_q <= 1'b0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            pv_q    <= pv_d;
            pl_q    <= pl_d;
            prd_q   <= prd_d;
            sb_q    <= sb_d;
            cred_q  <= cred_d;
            fcnt_q  <= fcnt_d;
            flush_q <= flush_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: directed scenarios then random traffic, every cycle
// checked against a queue-based reference model of in-flight instructions and pending loads.
module tb_decode_issue_ctrl;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned DEC_LAT    = 2;
    localparam int unsigned SKID_DEPTH = 4;
    localparam int unsigned FLUSH_CYC  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_issue_ctrl_if #(.XLEN(XLEN)) bus ();

    decode_issue_ctrl #(
        .XLEN(XLEN), .DEC_LAT(DEC_LAT), .SKID_DEPTH(SKID_DEPTH), .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .iClk(clk),
        .iRst(rst_n),
        .bus (bus)
    );

    typedef struct packed {
        logic        ready;
        logic        issue;
        logic        flush;
        logic [15:0] stall;
    } exp_t;

    typedef struct {
        int age;
        bit ld;
        int rd;
    } ent_t;

    exp_t        exp_q [$];
    ent_t        fly [$];
    int          m_mode;   // 0 run, 1 drain, 2 flush
    int          m_left;
    int          m_cred;
    int          m_stall;
    bit          m_flush;
    bit   [31:0] m_pend;
    bit          m_acc;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] a,
                                          input logic [4:0] b);
        return {7'b0, b, a, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] a);
        return {12'd0, a, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic bit pending(input int r);
        if (r == 0) return 1'b0;
        if (m_pend[r]) return 1'b1;
        foreach (fly[i]) if (fly[i].ld && fly[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        fly.delete();
        m_mode  = 0;
        m_left  = 0;
        m_cred  = SKID_DEPTH;
        m_stall = 0;
        m_flush = 1'b0;
        m_pend  = '0;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    endtask

    task automatic step(input bit v, input logic [31:0] ins, input bit cr, input bit wb,
                        input int wa, input bit br, input bit rst);
        logic [6:0] op;
        bit   issue, u1, u2, hz, busy, ser, ready;
        ent_t keep [$];
        @(negedge clk);
        bus.iInstValid   = v;
        bus.iInst        = ins;
        bus.iCredRet     = cr;
        bus.iWbValid     = wb;
        bus.iWbAddr      = 5'(wa);
        bus.iBranchTaken = br;
        rst_n            = !rst;
        m_acc            = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        op    = ins[6:0];
        issue = 1'b0;
        foreach (fly[i]) if (fly[i].age == DEC_LAT - 1) issue = 1'b1;
        u1    = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
        u2    = op inside {7'h33, 7'h23, 7'h63};
        hz    = (u1 && pending(int'(ins[19:15]))) || (u2 && pending(int'(ins[24:20])));
        busy  = (fly.size() != 0) || (m_pend != 0);
        ser   = (op == 7'h0F) || (op == 7'h73);
        if (br || m_cred == 0 || hz) ready = 1'b0;
        else if (m_mode == 0) ready = !(ser && busy);
        else if (m_mode == 1) ready = !busy;
        else ready = 1'b0;
        exp_q.push_back('{ready, issue, m_flush, 16'(m_stall)});

        m_acc = v && ready;
        if (v && !ready && m_stall < 65535) m_stall++;
        if (wb) m_pend[wa] = 1'b0;
        if (br) begin
            m_cred = m_cred + fly.size() + int'(cr);
            if (m_cred > SKID_DEPTH) m_cred = SKID_DEPTH;
            fly.delete();
            m_flush = (m_mode != 2);
            m_mode  = 2;
            m_left  = FLUSH_CYC;
        end else begin
            if (cr && !m_acc) begin
                if (m_cred < SKID_DEPTH) m_cred++;
            end else if (m_acc && !cr) begin
                m_cred--;
            end
            foreach (fly[i]) begin
                if (fly[i].age == DEC_LAT - 1) begin
                    if (fly[i].ld && fly[i].rd != 0) m_pend[fly[i].rd] = 1'b1;
                end else begin
                    keep.push_back('{age: fly[i].age + 1, ld: fly[i].ld, rd: fly[i].rd});
                end
            end
            if (m_acc) keep.push_back('{age: 0, ld: (op == 7'h03), rd: int'(ins[11:7])});
            fly     = keep;
            m_flush = 1'b0;
            if (m_mode == 0) begin
                if (v && ser && busy) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!busy) m_mode = 0;
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
        m_pend[0] = 1'b0;
    endtask

    task automatic idle(input int n, input bit cr);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, cr, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every presented cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("oInstReady", 16'(bus.oInstReady), 16'(e.ready));
                check("oIssueValid", 16'(bus.oIssueValid), 16'(e.issue));
                check("oFlush", 16'(bus.oFlush), 16'(e.flush));
                check("oStallCnt", bus.oStallCnt, e.stall);
            end
        end
    end

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h0F, 7'h73, 7'h6F};

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        logic [31:0] cur;
        logic [31:0] add123, add651, fence;
        add123 = enc_r(5'd1, 5'd2, 5'd3);
        add651 = enc_r(5'd6, 5'd5, 5'd1);
        fence  = 32'h0ff0000f;
        bus.iInstValid = 1'b0; bus.iInst = '0; bus.iCredRet = 1'b0;
        bus.iWbValid = 1'b0; bus.iWbAddr = '0; bus.iBranchTaken = 1'b0;
        model_reset();

        step(1'b1, add123, 1'b1, 1'b1, 3, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Credit exhaustion, then one ADD per returned credit.
        for (int i = 0; i < 8; i++) step(1'b1, add123, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, add123, 1'b1, 1'b0, 0, 1'b0, 1'b0);
            step(1'b1, add123, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        end
        idle(6, 1'b1);

        // Load-use stall released the cycle after writeback.
        step(1'b1, enc_lw(5'd5, 5'd0), 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, add651, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, add651, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, add651, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        idle(4, 1'b1);

        // x0 destination never blocks.
        step(1'b1, enc_lw(5'd0, 5'd1), 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, enc_r(5'd2, 5'd0, 5'd0), 1'b0, 1'b0, 0, 1'b0, 1'b0);
        idle(6, 1'b1);

        // Branch with two live slots at two credits: refund to full.
        step(1'b1, add123, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, add123, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, add123, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, add123, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        idle(6, 1'b1);

        // Writeback and issue of LW x7 in the same cycle: x7 remains pending.
        step(1'b1, enc_lw(5'd7, 5'd0), 1'b0, 1'b1, 7, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, enc_r(5'd1, 5'd7, 5'd2), 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, enc_r(5'd1, 5'd7, 5'd2), 1'b0, 1'b1, 7, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, enc_r(5'd1, 5'd7, 5'd2), 1'b0, 1'b0, 0, 1'b0, 1'b0);
        idle(6, 1'b1);

        // FENCE drains behind a load; a second drain is killed by a branch.
        step(1'b1, enc_lw(5'd3, 5'd0), 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, fence, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, fence, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, fence, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        idle(6, 1'b1);
        step(1'b1, enc_lw(5'd3, 5'd0), 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, fence, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, fence, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, fence, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        idle(6, 1'b1);

        // Random traffic with a mid-run reset.
        cur = rand_inst();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, cur, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                 $urandom_range(0, 24) == 0, i == 1500);
            if (m_acc || $urandom_range(0, 5) == 0) cur = rand_inst();
        end
        idle(3, 1'b0);
        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
